// File: rtl/dma_bus_pkg.sv
// Shared types and constants for the dual-master DMA bus responder.
package dma_bus_pkg;

    localparam int ADDR_W              = 8;
    localparam int DATA_W              = 32;
    localparam int DEFAULT_MEM_DEPTH   = 256;
    localparam int DEFAULT_GRANT_LIMIT = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/dma_bus_arbiter.sv
// Two-master bus arbiter: M0 wins ties, owners are never preempted unless
// DMA_BUS_RESP_TIMEOUT_EN is defined, which adds a grant-length limit.
module dma_bus_arbiter
    import dma_bus_pkg::*;
#(
    parameter int GRANT_LIMIT = DEFAULT_GRANT_LIMIT
) (
    input  logic Clk,
    input  logic reset,
    input  logic i_req0,
    input  logic i_req1,
    output logic o_grant0,
    output logic o_grant1
);

    arb_state_t r_state;
    arb_state_t w_next;
    logic       w_expired;

`ifdef DMA_BUS_RESP_TIMEOUT_EN
    localparam int CNT_W = $clog2(GRANT_LIMIT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GRANT_LIMIT - 1);

    logic [CNT_W-1:0] r_cnt;

    assign w_expired = (r_cnt == CNT_LAST);

    // Saturates at the limit so a lone owner can keep the bus without wrapping.
    always_ff @(posedge Clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if ((w_next != r_state) || (r_state == ST_IDLE)) begin
            r_cnt <= '0;
        end else if (!w_expired) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
`else
    assign w_expired = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        o_grant0 = 1'b0;
        o_grant1 = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_req0) begin
                    w_next = ST_GNT0;
                end else if (i_req1) begin
                    w_next = ST_GNT1;
                end
            end
            ST_GNT0: begin
                o_grant0 = 1'b1;
                if (!i_req0) begin
                    w_next = i_req1 ? ST_GNT1 : ST_IDLE;
                end else if (i_req1 && w_expired) begin
                    w_next = ST_GNT1;
                end
            end
            ST_GNT1: begin
                o_grant1 = 1'b1;
                if (!i_req1) begin
                    w_next = i_req0 ? ST_GNT0 : ST_IDLE;
                end else if (i_req0 && w_expired) begin
                    w_next = ST_GNT0;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/dma_bus_responder.sv
// Shared-bus target for CPU (M0) and DMAC (M1) with an on-chip word memory.
// Optional grant timeout: define DMA_BUS_RESP_TIMEOUT_EN.
module dma_bus_responder
    import dma_bus_pkg::*;
#(
    parameter int MEM_DEPTH   = DEFAULT_MEM_DEPTH,
    parameter int GRANT_LIMIT = DEFAULT_GRANT_LIMIT
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              M0_req,
    input  logic              M0_wr,
    input  logic [ADDR_W-1:0] M0_address,
    input  logic [DATA_W-1:0] M0_dout,
    output logic              M0_grant,
    input  logic              M1_req,
    input  logic              M1_wr,
    input  logic [ADDR_W-1:0] M1_address,
    input  logic [DATA_W-1:0] M1_dout,
    output logic              M1_grant,
    output logic [DATA_W-1:0] M_din
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_LIM = MEM_DEPTH[ADDR_W:0];

    logic [DATA_W-1:0] r_mem [0:MEM_DEPTH-1];
    logic [DATA_W-1:0] r_din;

    logic              w_grant0;
    logic              w_grant1;
    logic              w_access;
    logic              w_wr;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_inRange;
    logic [IDX_W-1:0]  w_idx;

    dma_bus_arbiter #(
        .GRANT_LIMIT (GRANT_LIMIT)
    ) u_arbiter (
        .Clk      (Clk),
        .reset    (reset),
        .i_req0   (M0_req),
        .i_req1   (M1_req),
        .o_grant0 (w_grant0),
        .o_grant1 (w_grant1)
    );

    always_comb begin
        w_access = w_grant0 | w_grant1;
        w_wr     = M0_wr;
        w_addr   = M0_address;
        w_wdata  = M0_dout;
        if (w_grant1) begin
            w_wr    = M1_wr;
            w_addr  = M1_address;
            w_wdata = M1_dout;
        end
    end

    assign w_inRange = ({1'b0, w_addr} < DEPTH_LIM);
    assign w_idx     = w_addr[IDX_W-1:0];

    // Gated by reset so a write presented alongside a mid-burst reset is lost.
    always_ff @(posedge Clk) begin
        if (!reset && w_access && w_wr && w_inRange) begin
            r_mem[w_idx] <= w_wdata;
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            r_din <= '0;
        end else if (w_access && !w_wr) begin
            r_din <= w_inRange ? r_mem[w_idx] : '0;
        end
    end

    assign M0_grant = w_grant0;
    assign M1_grant = w_grant1;
    assign M_din    = r_din;

endmodule

// File: tb/tb_dma_bus_responder.sv
// Directed bench for dma_bus_responder: a 256-word and a 16-word instance share
// all inputs so range handling can be compared side by side.
module tb_dma_bus_responder;

    logic        Clk = 1'b0;
    logic        reset;
    logic        m0Req, m0Wr, m1Req, m1Wr;
    logic [7:0]  m0Addr, m1Addr;
    logic [31:0] m0Dout, m1Dout;
    logic        m0Grant, m1Grant, sm0Grant, sm1Grant;
    logic [31:0] mDin, smDin;
    logic [31:0] copyBuf [4];

    int checkCount = 0;
    int errorCount = 0;

    always #5 Clk = ~Clk;

    dma_bus_responder #(
        .MEM_DEPTH   (256),
        .GRANT_LIMIT (4)
    ) u_dut (
        .Clk        (Clk),
        .reset      (reset),
        .M0_req     (m0Req),
        .M0_wr      (m0Wr),
        .M0_address (m0Addr),
        .M0_dout    (m0Dout),
        .M0_grant   (m0Grant),
        .M1_req     (m1Req),
        .M1_wr      (m1Wr),
        .M1_address (m1Addr),
        .M1_dout    (m1Dout),
        .M1_grant   (m1Grant),
        .M_din      (mDin)
    );

    dma_bus_responder #(
        .MEM_DEPTH   (16),
        .GRANT_LIMIT (4)
    ) u_dutSmall (
        .Clk        (Clk),
        .reset      (reset),
        .M0_req     (m0Req),
        .M0_wr      (m0Wr),
        .M0_address (m0Addr),
        .M0_dout    (m0Dout),
        .M0_grant   (sm0Grant),
        .M1_req     (m1Req),
        .M1_wr      (m1Wr),
        .M1_address (m1Addr),
        .M1_dout    (m1Dout),
        .M1_grant   (sm1Grant),
        .M_din      (smDin)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic applyStimulus(input bit master, input logic req, input logic wr,
                                 input logic [7:0] addr, input logic [31:0] data);
        if (master) begin
            m1Req = req; m1Wr = wr; m1Addr = addr; m1Dout = data;
        end else begin
            m0Req = req; m0Wr = wr; m0Addr = addr; m0Dout = data;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        applyStimulus(0, 1, 0, 8'h00, 32'h0);
        applyStimulus(1, 1, 0, 8'h00, 32'h0);
        tick();
        tick();
        checkOutput("rst_g0", {31'b0, m0Grant}, 32'd0);
        checkOutput("rst_g1", {31'b0, m1Grant}, 32'd0);
        checkOutput("rst_din", mDin, 32'd0);
        checkOutput("rst_din_small", smDin, 32'd0);

        reset = 1'b0;
        tick();
        checkOutput("post_rst_g0", {31'b0, m0Grant}, 32'd1);
        checkOutput("post_rst_g1", {31'b0, m1Grant}, 32'd0);

        // Preload through M0 while M1 withdraws its early request.
        applyStimulus(1, 0, 0, 8'h00, 32'h0);
        applyStimulus(0, 1, 1, 8'h00, 32'h12345678);
        tick();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 1, 8'(8'h0a + i), 32'((i + 1) * 100));
            tick();
        end
        applyStimulus(0, 1, 1, 8'h1a, 32'h5555AAAA);
        tick();
        applyStimulus(0, 0, 1, 8'h1a, 32'h5555AAAA);
        tick();
        checkOutput("m0_release", {31'b0, m0Grant}, 32'd0);

        // DMAC copy 0x0a..0x0d -> 0x14..0x17.
        applyStimulus(1, 1, 0, 8'h0a, 32'h0);
        tick();
        checkOutput("copy_g1", {31'b0, m1Grant}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 1, 0, 8'(8'h0a + i), 32'h0);
            tick();
            checkOutput("copy_rd", mDin, 32'((i + 1) * 100));
            copyBuf[i] = mDin;
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 1, 1, 8'(8'h14 + i), copyBuf[i]);
            tick();
            checkOutput("copy_wr_hold", mDin, 32'd400);
        end
        applyStimulus(1, 0, 1, 8'h17, copyBuf[3]);
        tick();
        checkOutput("copy_release", {31'b0, m1Grant}, 32'd0);

        applyStimulus(0, 1, 0, 8'h14, 32'h0);
        tick();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 0, 8'(8'h14 + i), 32'h0);
            tick();
            checkOutput("copy_readback", mDin, 32'((i + 1) * 100));
        end
        applyStimulus(0, 0, 0, 8'h17, 32'h0);
        tick();

        // Simultaneous requests: M0 first, then handoff without idle cycle.
        applyStimulus(0, 1, 0, 8'h00, 32'h0);
        applyStimulus(1, 1, 0, 8'h0a, 32'h0);
        tick();
        checkOutput("sim_g0", {31'b0, m0Grant}, 32'd1);
        checkOutput("sim_g1", {31'b0, m1Grant}, 32'd0);
        tick();
        checkOutput("sim_rd0", mDin, 32'h12345678);
        applyStimulus(0, 0, 0, 8'h00, 32'h0);
        tick();
        checkOutput("handoff_g0", {31'b0, m0Grant}, 32'd0);
        checkOutput("handoff_g1", {31'b0, m1Grant}, 32'd1);
        tick();
        checkOutput("sim_rd1", mDin, 32'd100);
        applyStimulus(1, 0, 0, 8'h0b, 32'h0);
        tick();
        checkOutput("sim_release", {31'b0, m1Grant}, 32'd0);
        tick();
        checkOutput("idle_hold", mDin, 32'd200);

        // Out-of-range write on the 16-word instance.
        applyStimulus(0, 1, 1, 8'h20, 32'hDEADBEEF);
        tick();
        tick();
        applyStimulus(0, 1, 0, 8'h20, 32'h0);
        tick();
        checkOutput("oor_rd_small", smDin, 32'h0);
        checkOutput("oor_rd_big", mDin, 32'hDEADBEEF);
        applyStimulus(0, 1, 0, 8'h00, 32'h0);
        tick();
        checkOutput("oor_mem0_small", smDin, 32'h12345678);
        applyStimulus(0, 0, 0, 8'h00, 32'h0);
        tick();

        // Grant timeout (limit 4) with M0 waiting.
        applyStimulus(1, 1, 0, 8'h0b, 32'h0);
        tick();
        checkOutput("to_g1", {31'b0, m1Grant}, 32'd1);
        applyStimulus(0, 1, 0, 8'h0c, 32'h0);
        for (int i = 1; i < 4; i++) begin
            tick();
            checkOutput("to_hold_g1", {31'b0, m1Grant}, 32'd1);
        end
        tick();
`ifdef DMA_BUS_RESP_TIMEOUT_EN
        checkOutput("to_switch_g0", {31'b0, m0Grant}, 32'd1);
        checkOutput("to_switch_g1", {31'b0, m1Grant}, 32'd0);
        tick();
        checkOutput("to_m0_rd", mDin, 32'd300);
`else
        checkOutput("to_keep_g0", {31'b0, m0Grant}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            checkOutput("to_keep_g1", {31'b0, m1Grant}, 32'd1);
        end
`endif
        applyStimulus(0, 0, 0, 8'h00, 32'h0);
        applyStimulus(1, 0, 0, 8'h00, 32'h0);
        tick();
        checkOutput("to_idle_g0", {31'b0, m0Grant}, 32'd0);
        checkOutput("to_idle_g1", {31'b0, m1Grant}, 32'd0);

        // Reset during an M1 write burst.
        applyStimulus(1, 1, 1, 8'h18, 32'hA1);
        tick();
        checkOutput("mb_g1", {31'b0, m1Grant}, 32'd1);
        tick();
        applyStimulus(1, 1, 1, 8'h19, 32'hA2);
        tick();
        applyStimulus(1, 1, 1, 8'h1a, 32'hA3);
        reset = 1'b1;
        tick();
        checkOutput("mb_rst_g1", {31'b0, m1Grant}, 32'd0);
        checkOutput("mb_rst_din", mDin, 32'd0);
        reset = 1'b0;
        applyStimulus(1, 0, 0, 8'h00, 32'h0);
        tick();

        applyStimulus(0, 1, 0, 8'h18, 32'h0);
        tick();
        tick();
        checkOutput("mb_rb_18", mDin, 32'hA1);
        applyStimulus(0, 1, 0, 8'h19, 32'h0);
        tick();
        checkOutput("mb_rb_19", mDin, 32'hA2);
        applyStimulus(0, 1, 0, 8'h1a, 32'h0);
        tick();
        checkOutput("mb_rb_1a", mDin, 32'h5555AAAA);
        applyStimulus(0, 0, 0, 8'h00, 32'h0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
